stepper_motion_ctrl: RTL and testbench

- Sequences the stepper step generator: accepts MOVE/HOME/STOP commands and drives its en, dir and 16-bit speed inputs.
- Counts generated steps and applies a linear delay ramp for accel/decel.
- Performs homing against the home switch and tracks signed absolute position.
- Sits between the scan-control/host register block and the stepper instance.

---
 rtl/stepper_ctrl_pkg.sv | 36 +++
 rtl/stepper_sync_2ff.sv | 28 ++
 rtl/stepper_motion_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 tb/tb_stepper_motion_ctrl.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stepper_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | stepper_ctrl_pkg : command/state encodings and default timing constants     |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
package stepper_ctrl_pkg;

  typedef enum logic [1:0] {
    NOP  = 2'd0,
    MOVE = 2'd1,
    HOME = 2'd2,
    STOP = 2'd3
  } cmd_op_t;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAKE      = 3'd1,
    ACCEL     = 3'd2,
    CRUISE    = 3'd3,
    DECEL     = 3'd4,
    HOME_SEEK = 3'd5,
    FAULT     = 3'd6
  } state_t;

  localparam logic [15:0]        DEF_DLY_START      = 16'd60000;
  localparam logic [15:0]        DEF_DLY_CRUISE     = 16'd0;
  localparam logic [15:0]        DEF_DLY_DEC        = 16'd500;
  localparam logic [15:0]        DEF_DLY_HOME       = 16'd30000;
  localparam logic               DEF_HOME_DIR       = 1'b0;
  localparam logic [23:0]        DEF_HOME_MAX_STEPS = 24'd2000000;
  localparam logic [19:0]        DEF_WAKE_CYCLES    = 20'd200000;
  localparam logic signed [31:0] DEF_POS_MIN        = -32'sd1000000;
  localparam logic signed [31:0] DEF_POS_MAX        = 32'sd1000000;

endpackage
`default_nettype wire

// File: rtl/stepper_sync_2ff.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | stepper_sync_2ff : two-flop synchroniser for asynchronous level inputs      |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module stepper_sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk_100M,
  input  logic nrst,
  input  logic d,
  output logic q
);

  logic [1:0] r_sync;

  always_ff @(posedge clk_100M or negedge nrst) begin
    if (!nrst) begin
      r_sync <= {2{RST_VAL}};
    end else begin
      r_sync <= {r_sync[0], d};
    end
  end

  assign q = r_sync[1];

endmodule
`default_nettype wire

// File: rtl/stepper_motion_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | stepper_motion_ctrl : MOVE/HOME/STOP sequencer with linear ramp for stepper |
// | Optional macro STEPPER_SOFT_LIMIT_EN: soft position limits on MOVE          |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module stepper_motion_ctrl
  import stepper_ctrl_pkg::*;
#(
  parameter logic [15:0] DLY_START      = DEF_DLY_START,
  parameter logic [15:0] DLY_CRUISE     = DEF_DLY_CRUISE,
  parameter logic [15:0] DLY_DEC        = DEF_DLY_DEC,
  parameter logic [15:0] DLY_HOME       = DEF_DLY_HOME,
  parameter logic        HOME_DIR       = DEF_HOME_DIR,
  parameter logic [23:0] HOME_MAX_STEPS = DEF_HOME_MAX_STEPS,
  parameter logic [19:0] WAKE_CYCLES    = DEF_WAKE_CYCLES
`ifdef STEPPER_SOFT_LIMIT_EN
  ,
  parameter logic signed [31:0] POS_MIN = DEF_POS_MIN,
  parameter logic signed [31:0] POS_MAX = DEF_POS_MAX
`endif
) (
  input  logic               clk_100M,
  input  logic               nrst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic               cmd_dir,
  input  logic [23:0]        cmd_steps,
  output logic               stp_en,
  output logic               stp_dir,
  output logic [15:0]        stp_speed,
  input  logic               stp_step,
  input  logic               mtr_nhome,
  input  logic               mtr_nflt,
  output logic               busy,
  output logic               done,
  output logic               fault,
  output logic               homed,
  output logic signed [31:0] position,
  output logic               cmd_err
);

  localparam logic [2:0] ST_IDLE      = IDLE;
  localparam logic [2:0] ST_WAKE      = WAKE;
  localparam logic [2:0] ST_ACCEL     = ACCEL;
  localparam logic [2:0] ST_CRUISE    = CRUISE;
  localparam logic [2:0] ST_DECEL     = DECEL;
  localparam logic [2:0] ST_HOME_SEEK = HOME_SEEK;
  localparam logic [2:0] ST_FAULT     = FAULT;

  localparam logic [1:0] OP_MOVE = MOVE;
  localparam logic [1:0] OP_HOME = HOME;
  localparam logic [1:0] OP_STOP = STOP;

  logic [2:0]         r_state;
  logic               r_live;
  logic               r_step_d;
  logic               r_en;
  logic               r_dir;
  logic [15:0]        r_speed;
  logic [23:0]        r_remaining;
  logic [23:0]        r_ramp;
  logic [19:0]        r_wake_cnt;
  logic [23:0]        r_home_cnt;
  logic               r_homing;
  logic               r_done;
  logic               r_cmd_err;
  logic               r_fault;
  logic               r_homed;
  logic signed [31:0] r_position;

  logic        w_nhome_s;
  logic        w_nflt_s;
  logic        w_counting;
  logic        w_flt_evt;
  logic        w_step;
  logic        w_stop;
  logic        w_accept;
  logic        w_busy_rej;
  logic        w_move_bad;
  logic [23:0] w_rem_dec;
  logic [23:0] w_ramp_inc;
  logic [23:0] w_ramp_dec;
  logic [16:0] w_acc17;
  logic [16:0] w_dec17;
  logic [15:0] w_spd_fast;
  logic [15:0] w_spd_slow;

  stepper_sync_2ff #(.RST_VAL(1'b1)) u_sync_nhome (
    .clk_100M (clk_100M),
    .nrst     (nrst),
    .d        (mtr_nhome),
    .q        (w_nhome_s)
  );

  stepper_sync_2ff #(.RST_VAL(1'b1)) u_sync_nflt (
    .clk_100M (clk_100M),
    .nrst     (nrst),
    .d        (mtr_nflt),
    .q        (w_nflt_s)
  );

  assign cmd_ready = r_live && (r_state == ST_IDLE);
  assign w_counting = (r_state == ST_ACCEL) || (r_state == ST_CRUISE) ||
                      (r_state == ST_DECEL) || (r_state == ST_HOME_SEEK);
  // A driver fault outranks a coincident step edge, so that edge is dropped
  assign w_flt_evt  = (r_state != ST_IDLE) && !w_nflt_s;
  assign w_step     = stp_step && !r_step_d && w_counting && !w_flt_evt;
  assign w_stop     = cmd_valid && (cmd_op == OP_STOP);
  assign w_accept   = cmd_valid && cmd_ready;
  assign w_busy_rej = cmd_valid && !cmd_ready && (cmd_op != OP_STOP);

  assign w_rem_dec  = r_remaining - 24'd1;
  assign w_ramp_inc = r_ramp + 24'd1;
  assign w_ramp_dec = (r_ramp != 24'd0) ? r_ramp - 24'd1 : 24'd0;
  // Ramp arithmetic is done 17 bits wide so over/underflow saturates cleanly
  assign w_acc17    = {1'b0, r_speed} - {1'b0, DLY_DEC};
  assign w_dec17    = {1'b0, r_speed} + {1'b0, DLY_DEC};
  assign w_spd_fast = (w_acc17[16] || (w_acc17[15:0] < DLY_CRUISE)) ? DLY_CRUISE : w_acc17[15:0];
  assign w_spd_slow = (w_dec17 > {1'b0, DLY_START}) ? DLY_START : w_dec17[15:0];

`ifdef STEPPER_SOFT_LIMIT_EN
  localparam logic signed [32:0] LIM_LO = {POS_MIN[31], POS_MIN};
  localparam logic signed [32:0] LIM_HI = {POS_MAX[31], POS_MAX};
  logic signed [32:0] w_target;
  assign w_target   = cmd_dir ? ({r_position[31], r_position} + {9'd0, cmd_steps})
                              : ({r_position[31], r_position} - {9'd0, cmd_steps});
  assign w_move_bad = !r_homed || (w_target < LIM_LO) || (w_target > LIM_HI);
`else
  assign w_move_bad = 1'b0;
`endif

  always_ff @(posedge clk_100M or negedge nrst) begin
    if (!nrst) begin
      r_state     <= ST_IDLE;
      r_live      <= 1'b0;
      r_step_d    <= 1'b0;
      r_en        <= 1'b0;
      r_dir       <= 1'b0;
      r_speed     <= DLY_START;
      r_remaining <= 24'd0;
      r_ramp      <= 24'd0;
      r_wake_cnt  <= 20'd0;
      r_home_cnt  <= 24'd0;
      r_homing    <= 1'b0;
      r_done      <= 1'b0;
      r_cmd_err   <= 1'b0;
      r_fault     <= 1'b0;
      r_homed     <= 1'b0;
      r_position  <= 32'sd0;
    end else begin
      r_live    <= 1'b1;
      r_step_d  <= stp_step;
      r_done    <= 1'b0;
      r_cmd_err <= w_busy_rej;

      if (w_step) begin
        r_position <= r_dir ? r_position + 32'sd1 : r_position - 32'sd1;
      end

      if (w_flt_evt) begin
        r_state <= ST_FAULT;
        r_en    <= 1'b0;
        r_fault <= 1'b1;
        r_homed <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_en <= 1'b0;
            if (w_accept) begin
              case (cmd_op)
                OP_MOVE: begin
                  if (w_move_bad) begin
                    r_cmd_err <= 1'b1;
                  end else if (cmd_steps == 24'd0) begin
                    r_done <= 1'b1;
                  end else begin
                    r_dir       <= cmd_dir;
                    r_remaining <= cmd_steps;
                    r_ramp      <= 24'd0;
                    r_speed     <= DLY_START;
                    r_en        <= 1'b1;
                    r_wake_cnt  <= 20'd0;
                    r_homing    <= 1'b0;
                    r_state     <= ST_WAKE;
                  end
                end
                OP_HOME: begin
                  r_dir      <= HOME_DIR;
                  r_speed    <= DLY_HOME;
                  r_en       <= 1'b1;
                  r_wake_cnt <= 20'd0;
                  r_homing   <= 1'b1;
                  r_state    <= ST_WAKE;
                end
                OP_STOP: r_done <= 1'b1;
                default: ;
              endcase
            end
          end

          ST_WAKE: begin
            if (w_stop) begin
              r_en    <= 1'b0;
              r_done  <= 1'b1;
              r_state <= ST_IDLE;
            end else if (r_wake_cnt == WAKE_CYCLES - 20'd1) begin
              r_home_cnt <= 24'd0;
              r_state    <= r_homing ? ST_HOME_SEEK : ST_ACCEL;
            end else begin
              r_wake_cnt <= r_wake_cnt + 20'd1;
            end
          end

          ST_ACCEL: begin
            if (w_step) begin
              r_remaining <= w_rem_dec;
              r_ramp      <= w_ramp_inc;
              r_speed     <= w_spd_fast;
              if (w_rem_dec == 24'd0) begin
                r_en    <= 1'b0;
                r_done  <= 1'b1;
                r_state <= ST_IDLE;
              end else if (w_rem_dec <= w_ramp_inc) begin
                r_state <= ST_DECEL;
              end else if (w_spd_fast == DLY_CRUISE) begin
                r_state <= ST_CRUISE;
              end
            end else if (w_stop) begin
              // With no ramp built up yet there is nothing to decelerate from
              if (r_ramp == 24'd0) begin
                r_en    <= 1'b0;
                r_done  <= 1'b1;
                r_state <= ST_IDLE;
              end else begin
                r_remaining <= r_ramp;
                r_state     <= ST_DECEL;
              end
            end
          end

          ST_CRUISE: begin
            if (w_step) begin
              r_remaining <= w_rem_dec;
              if (w_rem_dec == 24'd0) begin
                r_en    <= 1'b0;
                r_done  <= 1'b1;
                r_state <= ST_IDLE;
              end else if (w_rem_dec <= r_ramp) begin
                r_state <= ST_DECEL;
              end
            end else if (w_stop) begin
              r_remaining <= r_ramp;
              r_state     <= ST_DECEL;
            end
          end

          ST_DECEL: begin
            if (w_step) begin
              r_remaining <= w_rem_dec;
              r_ramp      <= w_ramp_dec;
              r_speed     <= w_spd_slow;
              if (w_rem_dec == 24'd0) begin
                r_en    <= 1'b0;
                r_done  <= 1'b1;
                r_state <= ST_IDLE;
              end
            end
          end

          ST_HOME_SEEK: begin
            if (!w_nhome_s) begin
              r_position <= 32'sd0;
              r_homed    <= 1'b1;
              r_en       <= 1'b0;
              r_done     <= 1'b1;
              r_state    <= ST_IDLE;
            end else if (w_step) begin
              r_home_cnt <= r_home_cnt + 24'd1;
              if (r_home_cnt + 24'd1 == HOME_MAX_STEPS) begin
                r_en    <= 1'b0;
                r_fault <= 1'b1;
                r_homed <= 1'b0;
                r_state <= ST_FAULT;
              end
            end else if (w_stop) begin
              r_en    <= 1'b0;
              r_done  <= 1'b1;
              r_state <= ST_IDLE;
            end
          end

          ST_FAULT: begin
            r_en <= 1'b0;
            if (w_stop) begin
              r_fault <= 1'b0;
              r_state <= ST_IDLE;
            end
          end

          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign stp_en    = r_en;
  assign stp_dir   = r_dir;
  assign stp_speed = r_speed;
  assign busy      = (r_state != ST_IDLE) && (r_state != ST_FAULT);
  assign done      = r_done;
  assign fault     = r_fault;
  assign homed     = r_homed;
  assign position  = r_position;
  assign cmd_err   = r_cmd_err;

endmodule
`default_nettype wire

// File: tb/tb_stepper_motion_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_stepper_motion_ctrl : directed self-checking bench for the motion ctrl   |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module tb_stepper_motion_ctrl;

  localparam logic [1:0] OP_MOVE = 2'd1;
  localparam logic [1:0] OP_HOME = 2'd2;
  localparam logic [1:0] OP_STOP = 2'd3;
  localparam int         WAKE_T  = 16;

  logic               clk_100M = 1'b0;
  logic               nrst = 1'b0;
  logic               cmd_valid = 1'b0;
  logic               cmd_ready;
  logic [1:0]         cmd_op = 2'd0;
  logic               cmd_dir = 1'b0;
  logic [23:0]        cmd_steps = 24'd0;
  logic               stp_en;
  logic               stp_dir;
  logic [15:0]        stp_speed;
  logic               stp_step = 1'b0;
  logic               mtr_nhome = 1'b1;
  logic               mtr_nflt = 1'b1;
  logic               busy;
  logic               done;
  logic               fault;
  logic               homed;
  logic signed [31:0] position;
  logic               cmd_err;

  int          n_checks = 0;
  int          n_errors = 0;
  int          n_done = 0;
  int          n_err = 0;
  logic [15:0] min_spd = 16'hFFFF;

  always #5 clk_100M = ~clk_100M;

  stepper_motion_ctrl #(
    .HOME_MAX_STEPS (24'd1500),
    .WAKE_CYCLES    (20'(WAKE_T))
  ) dut (
    .clk_100M  (clk_100M),
    .nrst      (nrst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_dir   (cmd_dir),
    .cmd_steps (cmd_steps),
    .stp_en    (stp_en),
    .stp_dir   (stp_dir),
    .stp_speed (stp_speed),
    .stp_step  (stp_step),
    .mtr_nhome (mtr_nhome),
    .mtr_nflt  (mtr_nflt),
    .busy      (busy),
    .done      (done),
    .fault     (fault),
    .homed     (homed),
    .position  (position),
    .cmd_err   (cmd_err)
  );

  // Pulse counters and speed floor, sampled mid-cycle
  always @(negedge clk_100M) begin
    if (done) n_done++;
    if (cmd_err) n_err++;
    if (stp_en && (stp_speed < min_spd)) min_spd = stp_speed;
  end

  task automatic chk(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_100M);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic dir, input logic [23:0] steps);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_dir   = dir;
    cmd_steps = steps;
    tick();
    cmd_valid = 1'b0;
    cmd_op    = 2'd0;
    tick();
  endtask

  task automatic do_step(output logic en_after);
    stp_step = 1'b1;
    tick();
    en_after = stp_en;
    stp_step = 1'b0;
    ticks(2);
  endtask

  initial begin
    logic en_a;
    int   d0, e0, k;

    // Reset state
    ticks(3);
    chk("rst_ready", cmd_ready, 0);
    chk("rst_en", stp_en, 0);
    chk("rst_dir", stp_dir, 0);
    chk("rst_speed", stp_speed, 60000);
    chk("rst_busy", busy, 0);
    chk("rst_fault", fault, 0);
    chk("rst_homed", homed, 0);
    chk("rst_pos", position, 0);
    nrst = 1'b1;
    ticks(2);
    chk("idle_ready", cmd_ready, 1);

    // Homing with the switch found after 1000 steps toward negative
    d0 = n_done;
    send_cmd(OP_HOME, 1'b1, 24'd0);
    chk("home_en", stp_en, 1);
    chk("home_dir", stp_dir, 0);
    chk("home_speed", stp_speed, 30000);
    chk("home_busy", busy, 1);
    ticks(WAKE_T + 4);
    for (int i = 0; i < 1000; i++) do_step(en_a);
    chk("home_pos_pre", position, -1000);
    chk("home_homed_pre", homed, 0);
    mtr_nhome = 1'b0;
    ticks(4);
    chk("home_pos", position, 0);
    chk("home_homed", homed, 1);
    chk("home_en_off", stp_en, 0);
    chk("home_done", n_done - d0, 1);
    mtr_nhome = 1'b1;
    ticks(3);

`ifdef STEPPER_SOFT_LIMIT_EN
    e0 = n_err;
    send_cmd(OP_MOVE, 1'b0, 24'd1000001);
    tick();
    chk("soft_lim_err", n_err - e0, 1);
    chk("soft_lim_busy", busy, 0);
`endif

    // MOVE 0 steps: done only
    d0 = n_done;
    send_cmd(OP_MOVE, 1'b1, 24'd0);
    tick();
    chk("move0_done", n_done - d0, 1);
    chk("move0_en", stp_en, 0);

    // MOVE +200: 100 accel steps to 10000, then 100 decel steps
    d0 = n_done;
    min_spd = 16'hFFFF;
    send_cmd(OP_MOVE, 1'b1, 24'd200);
    ticks(WAKE_T + 4);
    for (int i = 1; i <= 200; i++) begin
      do_step(en_a);
      if (i == 50)  chk("m200_spd50", stp_speed, 35000);
      if (i == 100) chk("m200_spd100", stp_speed, 10000);
      if (i == 150) chk("m200_spd150", stp_speed, 35000);
      if (i == 199) chk("m200_en199", en_a, 1);
      if (i == 200) chk("m200_en200", en_a, 0);
    end
    tick();
    chk("m200_pos", position, 200);
    chk("m200_done", n_done - d0, 1);
    chk("m200_min", min_spd, 10000);
    chk("m200_spd_end", stp_speed, 60000);
    chk("m200_busy", busy, 0);

    // MOVE +10: triangular profile bottoming at 57500
    d0 = n_done;
    min_spd = 16'hFFFF;
    send_cmd(OP_MOVE, 1'b1, 24'd10);
    ticks(WAKE_T + 4);
    for (int i = 1; i <= 10; i++) begin
      do_step(en_a);
      if (i == 5) chk("m10_spd5", stp_speed, 57500);
    end
    tick();
    chk("m10_pos", position, 210);
    chk("m10_min", min_spd, 57500);
    chk("m10_done", n_done - d0, 1);

    // STOP at step 50 of a 1000-step move: 50 more decel steps
    d0 = n_done;
    e0 = n_err;
    send_cmd(OP_MOVE, 1'b1, 24'd1000);
    ticks(WAKE_T + 4);
    for (int i = 0; i < 50; i++) do_step(en_a);
    chk("stop_spd50", stp_speed, 35000);
    send_cmd(OP_STOP, 1'b0, 24'd0);
    k = 0;
    en_a = 1'b1;
    while (en_a && k < 200) begin
      do_step(en_a);
      k++;
    end
    chk("stop_decel_steps", k, 50);
    chk("stop_pos", position, 310);
    chk("stop_done", n_done - d0, 1);
    chk("stop_no_err", n_err - e0, 0);

    // Driver fault during cruise
    send_cmd(OP_MOVE, 1'b1, 24'd300);
    ticks(WAKE_T + 4);
    for (int i = 0; i < 150; i++) do_step(en_a);
    chk("flt_cruise_spd", stp_speed, 0);
    chk("flt_pos", position, 460);
    mtr_nflt = 1'b0;
    ticks(3);
    chk("flt_fault", fault, 1);
    chk("flt_en", stp_en, 0);
    chk("flt_homed", homed, 0);
    chk("flt_busy", busy, 0);
    e0 = n_err;
    send_cmd(OP_MOVE, 1'b1, 24'd10);
    tick();
    chk("flt_move_err", n_err - e0, 1);
    chk("flt_move_en", stp_en, 0);
    mtr_nflt = 1'b1;
    ticks(3);
    send_cmd(OP_STOP, 1'b0, 24'd0);
    chk("flt_clear", fault, 0);
    chk("flt_ready", cmd_ready, 1);

`ifdef STEPPER_SOFT_LIMIT_EN
    e0 = n_err;
    send_cmd(OP_MOVE, 1'b1, 24'd10);
    tick();
    chk("soft_unhomed_err", n_err - e0, 1);
`endif

    // Homing without a switch exhausts the 1500-step budget
    send_cmd(OP_HOME, 1'b0, 24'd0);
    ticks(WAKE_T + 4);
    for (int i = 0; i < 1499; i++) do_step(en_a);
    chk("hflt_pre_fault", fault, 0);
    chk("hflt_pre_en", stp_en, 1);
    do_step(en_a);
    chk("hflt_en", en_a, 0);
    chk("hflt_fault", fault, 1);
    chk("hflt_pos", position, -1040);
    send_cmd(OP_STOP, 1'b0, 24'd0);
    chk("hflt_clear", fault, 0);

    // STOP while idle only pulses done
    d0 = n_done;
    send_cmd(OP_STOP, 1'b0, 24'd0);
    tick();
    chk("idle_stop_done", n_done - d0, 1);

    // Asynchronous reset mid-move
    send_cmd(OP_MOVE, 1'b1, 24'd10);
    ticks(WAKE_T + 4);
    for (int i = 0; i < 3; i++) do_step(en_a);
    chk("arst_busy_pre", busy, 1);
    nrst = 1'b0;
    #1;
    chk("arst_en", stp_en, 0);
    chk("arst_pos", position, 0);
    chk("arst_busy", busy, 0);
    chk("arst_ready", cmd_ready, 0);
    ticks(2);
    nrst = 1'b1;
    ticks(2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
